ec_point_validate: RTL and testbench
====================================

// Module: ec_point_validate
// PURPOSE
//  Checks that a point is on the short-Weierstrass curve y^2 = x^3 + A*x + B (mod prime).
//  Sits directly downstream of the scalar-multiply ladder and consumes its mGx/mGy/infinityP.
//  Also usable upstream to screen an externally supplied base/peer point before it enters the ladder.
//  Runs in constant time: three serial modular multiplies, whatever the data.
// PARAMETERS
//  integer_size  64  width of the field element, prime, A, B, Px, Py (W below)
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset: synchronous, active-high
//  go         in   1  level request; sampled in IDLE
//  prime      in   W  field modulus p; odd, p >= 5
//  A          in   W  curve coefficient A
//  B          in   W  curve coefficient B
//  Px         in   W  point x
//  Py         in   W  point y
//  infinityP  in   1  point is the point at infinity (ladder flag)
//  busy       out  1  high from LOAD through COMPARE
//  done       out  1  result valid (handshake below)
//  in_range   out  1  Px, Py, A and B are all < prime, and prime >= 5
//  on_curve   out  1  point satisfies the curve equation, or infinityP
// BEHAVIOUR
//  - Reset: state = IDLE; busy, done, in_range and on_curve = 0; the multiplier is aborted.
//    rst overrides every other event, including mid-operation.
//  - Inputs are registered in LOAD. After that, input changes and go deassertion are ignored until DONE.
//  - FSM states: IDLE, LOAD, RANGE, MUL_YY, MUL_XX, ADD_A, MUL_X3, ADD_B, COMPARE, DONE.
//    IDLE    : when go = 1 -> LOAD.
//    LOAD    : capture the inputs -> RANGE.
//    RANGE   : if infinityP: in_range = 1, on_curve = 1, go to DONE.
//              Else if any operand >= p or p < 5: in_range = 0, on_curve = 0, go to DONE.
//              Else: in_range = 1, start t0 = y*y, go to MUL_YY.
//    MUL_YY  : on mul_done, start t1 = x*x, go to MUL_XX.
//    MUL_XX  : on mul_done, go to ADD_A.
//    ADD_A   : t1 = (t1 + A) mod p, start t1*x, go to MUL_X3.
//    MUL_X3  : on mul_done, go to ADD_B.
//    ADD_B   : t1 = (t1 + B) mod p, go to COMPARE.
//    COMPARE : on_curve = (t0 == t1), go to DONE.
//    DONE    : done = 1. Stay while go = 1. Go to IDLE when go = 0.
//              If go is already low on entry, done is high for exactly 1 cycle.
//  - Latency, counted in edges from the go-sampling edge to done high:
//    full path = 3*W + 12; infinity or range-reject path = 4.
//  - Modular add: (W+1)-bit sum s = a + b; result = (s >= p) ? s - p : s. Both operands are < p.
//  - in_range and on_curve stay valid in DONE and hold until the next LOAD, which clears them.
//  - go held high after DONE -> IDLE: a new run starts (back-to-back operation allowed).
// STRUCTURE
//  - Shared package ecc_pkg holds:
//    the FSM state encodings (4-bit localparams);
//    the mod_add function (W+1-bit conditional subtract);
//    the MIN_PRIME = 5 constant.
//  - Sub-module mod_mul_serial #(integer_size): interleaved MSB-first shift-add modular multiplier.
//    Interface: clk, rst, start, a, b, p -> res, mul_done.
//    Each iteration: r = 2r mod p, then if b[i]: r = r + a mod p.
//    start is accepted in cycle 0. W iterations follow. mul_done pulses in cycle W+1 (W+2 cycles total).
//    res is held until the next start. All intermediates are W+1 bits wide.
// TESTING (integer_size = 8, p = 97, A = 2, B = 3; full-path latency 36)
//  1. P = (3,6), go pulsed -> done at edge 36, in_range = 1, on_curve = 1 (36 == 27 + 6 + 3).
//  2. P = (3,7) -> done at edge 36, in_range = 1, on_curve = 0 (49 != 36).
//  3. Px = 97 -> done at edge 4, in_range = 0, on_curve = 0; infinityP = 1 -> done at edge 4, on_curve = 1.
//  4. rst pulsed while in MUL_X3 -> next cycle: IDLE, busy/done/in_range/on_curve = 0.
//     A new go on (3,6) -> correct result.
//  5. go held high 50 cycles -> done stays high from edge 36 while go is high.
//     go dropped at edge 2 -> done is a single-cycle pulse at edge 36.
//  6. Random 200 points (half valid, half y+1 mod p) checked against a reference model.
//     Latency must be identical for every point.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve point checker: FSM encodings,
// the smallest modulus accepted and the modular adder used by every stage.
package ecc_pkg;

  // Widest field element the shared adder can serve; narrower callers zero-extend.
  localparam int ECC_MAX_W = 576;

  // Smallest modulus for which the curve check is meaningful.
  localparam int MIN_PRIME = 5;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LOAD    = 4'd1;
  localparam logic [3:0] ST_RANGE   = 4'd2;
  localparam logic [3:0] ST_MUL_YY  = 4'd3;
  localparam logic [3:0] ST_MUL_XX  = 4'd4;
  localparam logic [3:0] ST_ADD_A   = 4'd5;
  localparam logic [3:0] ST_MUL_X3  = 4'd6;
  localparam logic [3:0] ST_ADD_B   = 4'd7;
  localparam logic [3:0] ST_COMPARE = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    RANGE   = ST_RANGE,
    MUL_YY  = ST_MUL_YY,
    MUL_XX  = ST_MUL_XX,
    ADD_A   = ST_ADD_A,
    MUL_X3  = ST_MUL_X3,
    ADD_B   = ST_ADD_B,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } state_t;

  typedef logic [ECC_MAX_W-1:0] felem_t;

  // (a + b) mod p for a, b < p: one carry bit, then a single conditional subtract.
  function automatic felem_t mod_add(input felem_t a, input felem_t b, input felem_t p);
    logic [ECC_MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) begin
      s = s - {1'b0, p};
    end
    return s[ECC_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved MSB-first shift-add modular multiplier: res = a * b mod p.
// start is taken in cycle 0, one bit of b is consumed per cycle for W cycles,
// and mul_done pulses in cycle W+1. res holds until the next start.
module mod_mul_serial
  import ecc_pkg::*;
#(
  parameter int integer_size = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [integer_size-1:0] a,
  input  logic [integer_size-1:0] b,
  input  logic [integer_size-1:0] p,
  output logic [integer_size-1:0] res,
  output logic                    mul_done
);

  localparam int W  = integer_size;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_p;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_done;

  logic [W-1:0]  w_dbl;
  logic [W-1:0]  w_next;

  function automatic logic [W-1:0] fieldAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] m);
    return W'(mod_add(felem_t'(x), felem_t'(y), felem_t'(m)));
  endfunction

  // One ladder step: double the accumulator, then add a when the current bit of b is set.
  assign w_dbl  = fieldAdd(r_acc, r_acc, r_p);
  assign w_next = r_b[W-1] ? fieldAdd(w_dbl, r_a, r_p) : w_dbl;

  // Operand capture on start, then W iterations with b shifted out MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_p   <= p;
        r_acc <= '0;
        r_cnt <= CW'(W);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_acc <= w_next;
        r_b   <= r_b << 1;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign res      = r_acc;
  assign mul_done = r_done;

endmodule

// File: rtl/ec_point_validate.sv
// Checks that (Px, Py) lies on y^2 = x^3 + A*x + B (mod prime), with the
// point at infinity always accepted. The data path is three serial modular
// multiplies, so every accepted in-range point takes the same number of cycles.
module ec_point_validate
  import ecc_pkg::*;
#(
  parameter int integer_size = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [integer_size-1:0] prime,
  input  logic [integer_size-1:0] A,
  input  logic [integer_size-1:0] B,
  input  logic [integer_size-1:0] Px,
  input  logic [integer_size-1:0] Py,
  input  logic                    infinityP,
  output logic                    busy,
  output logic                    done,
  output logic                    in_range,
  output logic                    on_curve
);

  localparam int W = integer_size;

  state_t       r_state;
  logic [W-1:0] r_prime;
  logic [W-1:0] r_coefA;
  logic [W-1:0] r_coefB;
  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic         r_inf;
  logic [W-1:0] r_t0;
  logic [W-1:0] r_t1;
  logic         r_mulStart;
  logic         r_busy;
  logic         r_done;
  logic         r_inRange;
  logic         r_onCurve;

  logic         w_mulStart;
  logic         w_mulDone;
  logic         w_outOfRange;
  logic [W-1:0] w_mulA;
  logic [W-1:0] w_mulB;
  logic [W-1:0] w_mulRes;
  logic [W-1:0] w_t1PlusA;

  function automatic logic [W-1:0] fieldAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] m);
    return W'(mod_add(felem_t'(x), felem_t'(y), felem_t'(m)));
  endfunction

  assign w_outOfRange = (r_x >= r_prime) | (r_y >= r_prime) |
                        (r_coefA >= r_prime) | (r_coefB >= r_prime) |
                        (r_prime < W'(MIN_PRIME));

  // x^2 + A is formed straight from the multiplier result and fed back in the same cycle.
  assign w_t1PlusA  = fieldAdd(w_mulRes, r_coefA, r_prime);
  assign w_mulStart = r_mulStart | (r_state == ADD_A);

  // Multiplier operand select: y*y, then x*x, then (x^2 + A)*x.
  always_comb begin
    w_mulA = r_y;
    w_mulB = r_y;
    case (r_state)
      MUL_XX: begin
        w_mulA = r_x;
        w_mulB = r_x;
      end
      ADD_A: begin
        w_mulA = w_t1PlusA;
        w_mulB = r_x;
      end
      default: begin
        w_mulA = r_y;
        w_mulB = r_y;
      end
    endcase
  end

  mod_mul_serial #(
    .integer_size(W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mulStart),
    .a       (w_mulA),
    .b       (w_mulB),
    .p       (r_prime),
    .res     (w_mulRes),
    .mul_done(w_mulDone)
  );

  // Sequencer: capture, screen the operands, walk the three multiplies, compare, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prime    <= '0;
      r_coefA    <= '0;
      r_coefB    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inf      <= 1'b0;
      r_t0       <= '0;
      r_t1       <= '0;
      r_mulStart <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inRange  <= 1'b0;
      r_onCurve  <= 1'b0;
    end else begin
      r_mulStart <= 1'b0;
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (go) begin
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_prime   <= prime;
          r_coefA   <= A;
          r_coefB   <= B;
          r_x       <= Px;
          r_y       <= Py;
          r_inf     <= infinityP;
          r_inRange <= 1'b0;
          r_onCurve <= 1'b0;
          r_state   <= RANGE;
        end
        RANGE: begin
          if (r_inf) begin
            r_inRange <= 1'b1;
            r_onCurve <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end else if (w_outOfRange) begin
            r_inRange <= 1'b0;
            r_onCurve <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_inRange  <= 1'b1;
            r_mulStart <= 1'b1;
            r_state    <= MUL_YY;
          end
        end
        MUL_YY: begin
          if (w_mulDone) begin
            r_t0       <= w_mulRes;
            r_mulStart <= 1'b1;
            r_state    <= MUL_XX;
          end
        end
        MUL_XX: begin
          if (w_mulDone) begin
            r_state <= ADD_A;
          end
        end
        ADD_A: begin
          r_t1    <= w_t1PlusA;
          r_state <= MUL_X3;
        end
        MUL_X3: begin
          if (w_mulDone) begin
            r_state <= ADD_B;
          end
        end
        ADD_B: begin
          r_t1    <= fieldAdd(w_mulRes, r_coefB, r_prime);
          r_state <= COMPARE;
        end
        COMPARE: begin
          r_onCurve <= (r_t0 == r_t1);
          r_busy    <= 1'b0;
          r_state   <= DONE;
        end
        DONE: begin
          r_done <= 1'b1;
          if (!go) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign in_range = r_inRange;
  assign on_curve = r_onCurve;

endmodule

// File: tb/tb_ec_point_validate.sv
// Bench for ec_point_validate at W = 8 on the curve y^2 = x^3 + 2x + 3 mod 97,
// plus a few other moduli for the range and carry corners.
module tb_ec_point_validate;

  localparam int W         = 8;
  localparam int FULL_LAT  = 3 * W + 12;
  localparam int SHORT_LAT = 4;
  localparam int MAX_WAIT  = 120;
  localparam int NUM_VEC   = 14;
  localparam int NUM_RAND  = 200;

  logic         clk;
  logic         rst;
  logic         go;
  logic [W-1:0] prime;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Px;
  logic [W-1:0] Py;
  logic         infinityP;
  logic         busy;
  logic         done;
  logic         in_range;
  logic         on_curve;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] p;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         inf;
    logic         expRange;
    logic         expCurve;
    int           expLat;
  } vec_t;

  typedef struct {
    logic expRange;
    logic expCurve;
    int   expLat;
  } exp_t;

  vec_t         vecs[NUM_VEC];
  exp_t         expQ[$];
  logic [W-1:0] validX[$];
  logic [W-1:0] validY[$];
  int           vectorCount;
  int           missCount;

  ec_point_validate #(
    .integer_size(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .prime    (prime),
    .A        (A),
    .B        (B),
    .Px       (Px),
    .Py       (Py),
    .infinityP(infinityP),
    .busy     (busy),
    .done     (done),
    .in_range (in_range),
    .on_curve (on_curve)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string name, input int actual, input int required);
    vectorCount++;
    if (actual != required) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  function automatic exp_t refModel(input vec_t v);
    exp_t e;
    int x, y, p, a, b, lhs, rhs;
    x = int'(v.x);
    y = int'(v.y);
    p = int'(v.p);
    a = int'(v.a);
    b = int'(v.b);
    if (v.inf) begin
      e.expRange = 1'b1;
      e.expCurve = 1'b1;
      e.expLat   = SHORT_LAT;
    end else if (x >= p || y >= p || a >= p || b >= p || p < 5) begin
      e.expRange = 1'b0;
      e.expCurve = 1'b0;
      e.expLat   = SHORT_LAT;
    end else begin
      lhs = (y * y) % p;
      rhs = (((x * x) % p) * x + a * x + b) % p;
      e.expRange = 1'b1;
      e.expCurve = (lhs == rhs);
      e.expLat   = FULL_LAT;
    end
    return e;
  endfunction

  task automatic checkOutput(input bit seen, input int lat);
    exp_t e;
    e = expQ.pop_front();
    checkValue("done_timeout", int'(seen), 1);
    checkValue("latency", lat, e.expLat);
    checkValue("in_range", int'(in_range), int'(e.expRange));
    checkValue("on_curve", int'(on_curve), int'(e.expCurve));
    checkValue("busy_at_done", int'(busy), 0);
    @(posedge clk);
    #1;
    checkValue("done_pulse_width", int'(done), 0);
    checkValue("in_range_hold", int'(in_range), int'(e.expRange));
    checkValue("on_curve_hold", int'(on_curve), int'(e.expCurve));
  endtask

  task automatic applyStimulus(input vec_t v, input exp_t e, input int goHold);
    int edgeCnt;
    bit seen;
    @(negedge clk);
    Px        = v.x;
    Py        = v.y;
    prime     = v.p;
    A         = v.a;
    B         = v.b;
    infinityP = v.inf;
    go        = 1'b1;
    expQ.push_back(e);
    edgeCnt = 0;
    seen    = 1'b0;
    while (!seen && edgeCnt < MAX_WAIT) begin
      @(posedge clk);
      #1;
      edgeCnt++;
      if (edgeCnt >= goHold) go = 1'b0;
      if (edgeCnt == 2) begin
        checkValue("busy_during_run", int'(busy), 1);
        Px        = ~v.x;
        Py        = ~v.y;
        prime     = ~v.p;
        A         = ~v.a;
        B         = ~v.b;
        infinityP = ~v.inf;
      end
      seen = done;
    end
    checkOutput(seen, edgeCnt);
  endtask

  // Main sequence: reset, table vectors, go-held and mid-run reset corners, random points.
  initial begin
    vec_t v;
    exp_t e;
    int   idx;
    vectorCount = 0;
    missCount   = 0;
    rst       = 1'b1;
    go        = 1'b0;
    prime     = '0;
    A         = '0;
    B         = '0;
    Px        = '0;
    Py        = '0;
    infinityP = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_busy", int'(busy), 0);
    checkValue("reset_done", int'(done), 0);
    checkValue("reset_in_range", int'(in_range), 0);
    checkValue("reset_on_curve", int'(on_curve), 0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = '{x:3,   y:6,  p:97,  a:2,  b:3,   inf:0, expRange:1, expCurve:1, expLat:FULL_LAT};
    vecs[1]  = '{x:3,   y:7,  p:97,  a:2,  b:3,   inf:0, expRange:1, expCurve:0, expLat:FULL_LAT};
    vecs[2]  = '{x:97,  y:6,  p:97,  a:2,  b:3,   inf:0, expRange:0, expCurve:0, expLat:SHORT_LAT};
    vecs[3]  = '{x:3,   y:7,  p:97,  a:2,  b:3,   inf:1, expRange:1, expCurve:1, expLat:SHORT_LAT};
    vecs[4]  = '{x:3,   y:97, p:97,  a:2,  b:3,   inf:0, expRange:0, expCurve:0, expLat:SHORT_LAT};
    vecs[5]  = '{x:3,   y:6,  p:97,  a:97, b:3,   inf:0, expRange:0, expCurve:0, expLat:SHORT_LAT};
    vecs[6]  = '{x:3,   y:6,  p:97,  a:2,  b:97,  inf:0, expRange:0, expCurve:0, expLat:SHORT_LAT};
    vecs[7]  = '{x:1,   y:1,  p:3,   a:1,  b:1,   inf:0, expRange:0, expCurve:0, expLat:SHORT_LAT};
    vecs[8]  = '{x:1,   y:1,  p:5,   a:2,  b:3,   inf:0, expRange:1, expCurve:1, expLat:FULL_LAT};
    vecs[9]  = '{x:96,  y:0,  p:97,  a:2,  b:3,   inf:0, expRange:1, expCurve:1, expLat:FULL_LAT};
    vecs[10] = '{x:96,  y:1,  p:97,  a:2,  b:3,   inf:0, expRange:1, expCurve:0, expLat:FULL_LAT};
    vecs[11] = '{x:200, y:6,  p:97,  a:2,  b:3,   inf:1, expRange:1, expCurve:1, expLat:SHORT_LAT};
    vecs[12] = '{x:250, y:0,  p:251, a:2,  b:3,   inf:0, expRange:1, expCurve:1, expLat:FULL_LAT};
    vecs[13] = '{x:250, y:1,  p:251, a:2,  b:3,   inf:0, expRange:1, expCurve:0, expLat:FULL_LAT};

    for (int i = 0; i < NUM_VEC; i++) begin
      e.expRange = vecs[i].expRange;
      e.expCurve = vecs[i].expCurve;
      e.expLat   = vecs[i].expLat;
      applyStimulus(vecs[i], e, (i == 0) ? 2 : 1);
    end

    // go held high: done rises on time and stays up until go drops.
    @(negedge clk);
    Px = 8'd3; Py = 8'd6; prime = 8'd97; A = 8'd2; B = 8'd3; infinityP = 1'b0;
    go = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k == FULL_LAT - 1) checkValue("hold_done_early", int'(done), 0);
      if (k == FULL_LAT) checkValue("hold_done_rise", int'(done), 1);
      if (k == 50) begin
        checkValue("hold_done_stays", int'(done), 1);
        checkValue("hold_on_curve", int'(on_curve), 1);
      end
    end
    go = 1'b0;
    @(posedge clk);
    #1;
    checkValue("hold_done_after_drop", int'(done), 1);
    @(posedge clk);
    #1;
    checkValue("hold_done_cleared", int'(done), 0);

    // Reset while the third multiply is running, then a clean rerun.
    @(negedge clk);
    Px = 8'd3; Py = 8'd6; prime = 8'd97; A = 8'd2; B = 8'd3; infinityP = 1'b0;
    go = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) go = 1'b0;
    end
    checkValue("pre_reset_busy", int'(busy), 1);
    checkValue("pre_reset_in_range", int'(in_range), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("midrun_reset_busy", int'(busy), 0);
    checkValue("midrun_reset_done", int'(done), 0);
    checkValue("midrun_reset_in_range", int'(in_range), 0);
    checkValue("midrun_reset_on_curve", int'(on_curve), 0);
    e.expRange = 1'b1;
    e.expCurve = 1'b1;
    e.expLat   = FULL_LAT;
    applyStimulus(vecs[0], e, 1);

    // Random points: half on the curve, half with y nudged by one.
    for (int x = 0; x < 97; x++) begin
      for (int y = 0; y < 97; y++) begin
        if ((y * y) % 97 == ((x * x) % 97 * x + 2 * x + 3) % 97) begin
          validX.push_back(W'(x));
          validY.push_back(W'(y));
        end
      end
    end
    for (int i = 0; i < NUM_RAND; i++) begin
      idx   = int'($urandom_range(0, validX.size() - 1));
      v.x   = validX[idx];
      v.y   = (i % 2 == 1) ? W'((int'(validY[idx]) + 1) % 97) : validY[idx];
      v.p   = 8'd97;
      v.a   = 8'd2;
      v.b   = 8'd3;
      v.inf = 1'b0;
      v.expRange = 1'b0;
      v.expCurve = 1'b0;
      v.expLat   = 0;
      e = refModel(v);
      applyStimulus(v, e, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
